// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control sequencer.
// State codes are also decoded by the datapath blocks that watch `estado`.
package controle_pkg;

  localparam logic [3:0] S_IF    = 4'd0;
  localparam logic [3:0] S_ID    = 4'd1;
  localparam logic [3:0] S_EX    = 4'd2;
  localparam logic [3:0] S_MEM   = 4'd3;
  localparam logic [3:0] S_WB    = 4'd4;
  localparam logic [3:0] S_PCUP  = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  localparam logic [3:0] S_PAUSE = 4'd10;

  localparam logic [31:0] HALT_WORD_DEF = 32'h0000_0000;

  // Width of the shared wait counter: enough for the largest phase wait,
  // never less than one bit.
  function automatic int espera_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Loadable down-counter shared by the EX/MEM/WB phases.
// Ports: clk, rst (sync, active-high), load/load_val (load wins over
// counting), cnt (current value), done (cnt == 0; counting stops there).
module contador_espera #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  assign done = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (!done) cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control sequencer for the RISC-V datapath.
// Sequence IF->ID->EX->MEM->WB->PCUP->IF with per-phase hold lengths,
// optional MEM skip, single-step PAUSE, HALT/resume and two counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instrucao           fetched word, sampled while estado=ID
//   mem_access          load/store flag, sampled while estado=ID
//   step_mode, step     pause after each instruction / leave PAUSE
//   resume              leave HALT
//   estado              current state code (controle_pkg S_*)
//   fim                 high while in HALT ("final" is a reserved word)
//   en_if..en_pc        first-cycle strobe of each phase
//   ciclos, instrucoes  active-cycle and retired-instruction counters
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int          WAIT_EX   = 2,
  parameter int          WAIT_MEM  = 0,
  parameter int          WAIT_WB   = 2,
  parameter int          SKIP_MEM  = 0,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrucao,
  input  logic             mem_access,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  output logic [3:0]       estado,
  output logic             fim,
  output logic             en_if,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             en_pc,
  output logic [CNT_W-1:0] ciclos,
  output logic [CNT_W-1:0] instrucoes
);

  localparam int CW = espera_width(WAIT_EX, WAIT_MEM, WAIT_WB);

  logic [3:0]    nxt;
  logic [CW-1:0] cnt, load_val;
  logic          done, load, first, mem_lat;

  function automatic logic [CW-1:0] wait_of(input logic [3:0] s);
    case (s)
      S_EX:    wait_of = CW'(WAIT_EX);
      S_MEM:   wait_of = CW'(WAIT_MEM);
      S_WB:    wait_of = CW'(WAIT_WB);
      default: wait_of = '0;
    endcase
  endfunction

  always_comb begin
    nxt = estado;
    case (estado)
      S_IF:    nxt = S_ID;
      S_ID:    nxt = (instrucao == HALT_WORD) ? S_HALT : S_EX;
      S_EX:    if (done) nxt = ((SKIP_MEM != 0) && !mem_lat) ? S_WB : S_MEM;
      S_MEM:   if (done) nxt = S_WB;
      S_WB:    if (done) nxt = S_PCUP;
      S_PCUP:  nxt = step_mode ? S_PAUSE : S_IF;
      S_PAUSE: if (step || !step_mode) nxt = S_IF;
      S_HALT:  if (resume) nxt = S_IF;
      default: nxt = S_IF;
    endcase
  end

  // Reload on every state change so the counter always holds the new
  // phase's wait (0 for single-cycle phases) on its first cycle.
  assign load     = (nxt != estado);
  assign load_val = wait_of(nxt);

  contador_espera #(.W(CW)) u_espera (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .done     (done)
  );

  // Counter still at its entry load marks the first cycle of a visit.
  assign first  = !rst && (cnt == wait_of(estado));
  assign en_if  = first && (estado == S_IF);
  assign en_id  = first && (estado == S_ID);
  assign en_ex  = first && (estado == S_EX);
  assign en_mem = first && (estado == S_MEM);
  assign en_wb  = first && (estado == S_WB);
  assign en_pc  = first && (estado == S_PCUP);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= S_IF;
      fim        <= 1'b0;
      mem_lat    <= 1'b0;
      ciclos     <= '0;
      instrucoes <= '0;
    end else begin
      estado <= nxt;
      fim    <= (nxt == S_HALT);
      if (estado == S_ID) mem_lat <= mem_access;
      if (estado != S_HALT && estado != S_PAUSE) ciclos <= ciclos + CNT_W'(1);
      if (estado == S_PCUP) instrucoes <= instrucoes + CNT_W'(1);
    end
  end

endmodule
